// File: rtl/ssd_pkg.sv
// ssd_pkg: shared seven-segment decode table and polarity helpers
package ssd_pkg;
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_OFF = 7'h00;
  function automatic logic [6:0] seg_pol(input logic [6:0] s, input bit al);
    return al ? ~s : s;
  endfunction
endpackage

// File: rtl/hex2seg.sv
// hex2seg: nibble to active-high {g,f,e,d,c,b,a} segment pattern
module hex2seg
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed seven-segment scanner with frame-aligned value updates
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int NIB_W       = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS*NIB_W-1:0]   value_in,
  input  logic                      value_vld,
  output logic                      value_rdy,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      blank_lz,
  output logic [DIGITS-1:0]         an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_done
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam bit AL = ACTIVE_LOW != 0;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DIGITS*NIB_W-1:0] disp_reg, pend_val;
  logic [DIGITS-1:0] disp_dp, pend_dp, sel;
  logic [3:0] nib;
  logic [6:0] hex;
  logic tick, wrap, blank;
  assign tick = cnt == CW'(REFRESH_DIV - 1);
  assign wrap = tick && idx == IW'(DIGITS - 1);
  assign nib = disp_reg[idx*NIB_W +: NIB_W];
  assign sel = DIGITS'(1) << idx;
  // a digit is a leading zero when it and every more significant nibble are zero
  assign blank = blank_lz && idx != '0 && (disp_reg >> (idx*NIB_W)) == '0;
  hex2seg u_dec (.nib(nib), .seg(hex));
  // value_rdy doubles as the pending-empty flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      value_rdy  <= 1'b1;
      frame_done <= 1'b0;
      an         <= AL ? '1 : '0;
      seg        <= seg_pol(SEG_OFF, AL);
      dp         <= AL;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      frame_done <= wrap;
      if (value_vld && value_rdy) begin
        pend_val  <= value_in;
        pend_dp   <= dp_in;
        value_rdy <= 1'b0;
      end else if (wrap && !value_rdy) begin
        disp_reg  <= pend_val;
        disp_dp   <= pend_dp;
        value_rdy <= 1'b1;
      end
      an  <= AL ? ~sel : sel;
      seg <= seg_pol(blank ? SEG_OFF : hex, AL);
      dp  <= disp_dp[idx] ^ AL;
    end
  end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed and random checks against a cycle-count based display model
module tb_ssd_scan_ctrl;
  logic clk = 1'b0;
  logic rst, value_vld, value_rdy, blank_lz, dp, frame_done;
  logic [15:0] value_in;
  logic [3:0] dp_in, an;
  logic [6:0] seg;
  int tests = 0, fails = 0, k = 0, slot = 0;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_dp, m_pdp;
  bit m_full;
  logic [6:0] cap [4];
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  always #5 clk = ~clk;
  ssd_scan_ctrl #(.DIGITS(4), .NIB_W(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .value_vld(value_vld), .value_rdy(value_rdy),
    .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // edge k after reset shows slot ((k-1)/4)%4; the frame wraps before every edge with k%16==0
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    bit bl;
    @(posedge clk);
    if (rst) begin
      k = 0; m_disp = 0; m_dp = 0; m_full = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      k++;
      slot = ((k - 1) / 4) % 4;
      bl = blank_lz && slot > 0 && (m_disp >> (slot * 4)) == 0;
      e_an = ~(4'b1 << slot);
      e_seg = bl ? 7'h7F : ~hex_tab[m_disp[slot*4 +: 4]];
      e_dp = ~m_dp[slot];
      e_fd = (k % 16 == 0);
      if (value_vld && !m_full) begin
        m_pend = value_in; m_pdp = dp_in; m_full = 1;
      end else if (k % 16 == 0 && m_full) begin
        m_disp = m_pend; m_dp = m_pdp; m_full = 0;
      end
    end
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_done", frame_done, e_fd);
    chk("value_rdy", value_rdy, !m_full);
    if (!rst) cap[slot] = seg;
  endtask
  task automatic run_to_wrap();
    while (k % 16 != 0) step();
  endtask
  initial begin
    rst = 1; value_vld = 0; value_in = 0; dp_in = 0; blank_lz = 1;
    repeat (3) step();
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    rst = 0;
    step();
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 7'h40);
    while (k < 22) step();
    value_in = 16'h12AF; dp_in = 4'b0010; value_vld = 1;
    step();
    value_vld = 0;
    chk("rdy_drop", value_rdy, 0);
    run_to_wrap();
    repeat (16) step();
    chk("d0_F", cap[0], 7'h0E);
    chk("d1_A", cap[1], 7'h08);
    chk("d2_2", cap[2], 7'h24);
    chk("d3_1", cap[3], 7'h79);
    chk("rdy_back", value_rdy, 1);
    value_in = 16'h0001; value_vld = 1;
    step();
    value_in = 16'h0002;
    step();
    chk("bp_rdy", value_rdy, 0);
    run_to_wrap();
    step();
    value_vld = 0;
    chk("bp_acc2", value_rdy, 0);
    repeat (15) step();
    chk("bp_d0_1", cap[0], 7'h79);
    chk("bp_d1_blank", cap[1], 7'h7F);
    run_to_wrap();
    repeat (16) step();
    chk("bp_d0_2", cap[0], 7'h24);
    value_in = 16'h0050; dp_in = 4'b0100; value_vld = 1;
    step();
    value_vld = 0;
    run_to_wrap();
    repeat (16) step();
    chk("lz_d3", cap[3], 7'h7F);
    chk("lz_d2", cap[2], 7'h7F);
    chk("lz_d1", cap[1], 7'h12);
    chk("lz_d0", cap[0], 7'h40);
    blank_lz = 0;
    repeat (16) step();
    chk("nolz_d3", cap[3], 7'h40);
    chk("nolz_d2", cap[2], 7'h40);
    repeat (600) begin
      value_vld = ($urandom % 6 == 0);
      value_in = 16'($urandom) & (16'hFFFF >> (4 * ($urandom % 4)));
      dp_in = 4'($urandom);
      if ($urandom % 20 == 0) blank_lz = ~blank_lz;
      step();
    end
    value_vld = 0; blank_lz = 1;
    run_to_wrap();
    step();
    value_in = 16'h9999; dp_in = 4'hF; value_vld = 1;
    step();
    value_vld = 0;
    step();
    chk("pre_rst_full", value_rdy, 0);
    rst = 1;
    step();
    rst = 0;
    step();
    step();
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_rdy", value_rdy, 1);
    repeat (40) step();
    chk("post_rst_d0", cap[0], 7'h40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
